// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory address and
// fills the IF/ID register, with stall, redirect, halt-on-ecall/ebreak and fault handling.
module fetch_stage #(
  parameter int unsigned ADDR_W   = 6,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_data,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_target,
  output logic              if_id_valid,
  output logic [31:0]       if_id_inst,
  output logic [31:0]       if_id_pc,
  output logic              halted,
  output logic              fault
);

  localparam int unsigned XLEN       = 32;
  localparam logic [31:0] ECALL_INST  = 32'h0000_0073;
  localparam logic [31:0] EBREAK_INST = 32'h0010_0073;
  localparam logic [31:0] PC_STEP     = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2,
    ST_FAULT  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic              valid_q, valid_d;
  logic [XLEN-1:0]   inst_q, inst_d;
  logic [XLEN-1:0]   ifpc_q, ifpc_d;
  logic              halted_q, halted_d;
  logic              fault_q, fault_d;

  logic              pc_oor_c;
  logic              is_halt_c;
  logic              target_misaligned_c;

  // The PC leaves the addressable range once any bit above the memory index is set.
  assign pc_oor_c            = (pc_q >> ADDR_W) != '0;
  assign is_halt_c           = (imem_data == ECALL_INST) || (imem_data == EBREAK_INST);
  assign target_misaligned_c = redirect_target[1:0] != 2'b00;

  // State and IF/ID register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      pc_q     <= RESET_PC;
      valid_q  <= 1'b0;
      inst_q   <= NOP_INST;
      ifpc_q   <= '0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      inst_q   <= inst_d;
      ifpc_q   <= ifpc_d;
      halted_q <= halted_d;
      fault_q  <= fault_d;
    end
  end

  // Next-state logic; every path starts from "hold everything".
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    valid_d  = valid_q;
    inst_d   = inst_q;
    ifpc_d   = ifpc_q;
    halted_d = halted_q;
    fault_d  = fault_q;

    unique case (state_q)
      ST_IDLE: begin
        valid_d = 1'b0;
        inst_d  = NOP_INST;
        state_d = ST_RUN;
      end

      ST_RUN, ST_HALTED: begin
        if (redirect_valid) begin
          // Redirect wins over stall and cancels a wrong-path halt; if_id_pc is kept.
          pc_d     = redirect_target;
          valid_d  = 1'b0;
          inst_d   = NOP_INST;
          halted_d = 1'b0;
          if (target_misaligned_c) begin
            state_d = ST_FAULT;
            fault_d = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end else if (state_q == ST_HALTED) begin
          valid_d = 1'b0;
          inst_d  = NOP_INST;
        end else if (stall) begin
          state_d = ST_RUN;
        end else if (pc_oor_c) begin
          valid_d = 1'b0;
          inst_d  = NOP_INST;
          state_d = ST_FAULT;
          fault_d = 1'b1;
        end else begin
          valid_d = 1'b1;
          inst_d  = imem_data;
          ifpc_d  = pc_q;
          if (is_halt_c) begin
            state_d  = ST_HALTED;
            halted_d = 1'b1;
          end else begin
            pc_d = pc_q + PC_STEP;
          end
        end
      end

      ST_FAULT: begin
        valid_d = 1'b0;
        inst_d  = NOP_INST;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign imem_addr   = pc_q[ADDR_W-1:0];
  assign if_id_valid = valid_q;
  assign if_id_inst  = inst_q;
  assign if_id_pc    = ifpc_q;
  assign halted      = halted_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a 64-byte combinational instruction memory.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] EBR = 32'h0010_0073;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  imem_addr;
  logic [31:0] imem_data;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        if_id_valid;
  logic [31:0] if_id_inst;
  logic [31:0] if_id_pc;
  logic        halted;
  logic        fault;

  logic [31:0] mem [16];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr[5:2]];

  fetch_stage #(.ADDR_W(6)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_addr       (imem_addr),
    .imem_data       (imem_data),
    .stall           (stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .if_id_valid     (if_id_valid),
    .if_id_inst      (if_id_inst),
    .if_id_pc        (if_id_pc),
    .halted          (halted),
    .fault           (fault)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle before sampling/driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic v, input logic [31:0] inst,
                            input logic [31:0] pc);
    check_val({tag, ".valid"}, 32'(if_id_valid), 32'(v));
    check_val({tag, ".inst"}, if_id_inst, inst);
    check_val({tag, ".pc"}, if_id_pc, pc);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'hA000_0000 + 32'(i);
    rst = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;
    #2;

    // Reset held two cycles.
    step(); step();
    check_ifid("reset", 1'b0, NOP, 32'h0);
    check_val("reset.halted", 32'(halted), 32'h0);
    check_val("reset.fault", 32'(fault), 32'h0);
    check_val("reset.addr", 32'(imem_addr), 32'h0);

    // IDLE cycle, then W0, W1.
    rst = 1'b1;
    step();
    check_ifid("idle", 1'b0, NOP, 32'h0);
    step();
    check_ifid("w0", 1'b1, 32'hA000_0000, 32'h0);
    step();
    check_ifid("w1", 1'b1, 32'hA000_0001, 32'h4);

    // Stall three cycles.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_ifid("stall", 1'b1, 32'hA000_0001, 32'h4);
      check_val("stall.addr", 32'(imem_addr), 32'h8);
    end
    stall = 1'b0;
    step();
    check_ifid("w2", 1'b1, 32'hA000_0002, 32'h8);

    // Redirect beats simultaneous stall.
    stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h20;
    step();
    check_ifid("redir", 1'b0, NOP, 32'h8);
    check_val("redir.addr", 32'(imem_addr), 32'h20);
    stall = 1'b0; redirect_valid = 1'b0;
    step();
    check_ifid("redir.tgt", 1'b1, 32'hA000_0008, 32'h20);

    // Halt on ebreak at address 12.
    mem[3] = EBR;
    redirect_valid = 1'b1; redirect_target = 32'hC;
    step();
    redirect_valid = 1'b0;
    step();
    check_ifid("halt.fetch", 1'b1, EBR, 32'hC);
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      check_ifid("halted", 1'b0, NOP, 32'hC);
      check_val("halted.flag", 32'(halted), 32'h1);
      check_val("halted.addr", 32'(imem_addr), 32'hC);
    end
    stall = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h4;
    step();
    check_val("unhalt.flag", 32'(halted), 32'h0);
    check_val("unhalt.addr", 32'(imem_addr), 32'h4);
    check_ifid("unhalt", 1'b0, NOP, 32'hC);
    redirect_valid = 1'b0;
    step();
    check_ifid("resume", 1'b1, 32'hA000_0001, 32'h4);

    // Misaligned redirect faults; later redirect ignored; reset clears.
    redirect_valid = 1'b1; redirect_target = 32'h22;
    step();
    check_val("mis.fault", 32'(fault), 32'h1);
    check_val("mis.addr", 32'(imem_addr), 32'h22);
    check_ifid("mis", 1'b0, NOP, 32'h4);
    redirect_valid = 1'b0;
    step();
    redirect_valid = 1'b1; redirect_target = 32'h0;
    step();
    redirect_valid = 1'b0;
    check_val("mis.sticky", 32'(fault), 32'h1);
    check_val("mis.ignore", 32'(imem_addr), 32'h22);
    check_ifid("mis.hold", 1'b0, NOP, 32'h4);
    step();
    check_val("mis.stay", 32'(if_id_valid), 32'h0);
    rst = 1'b0;
    step();
    rst = 1'b1;
    check_val("rst.fault", 32'(fault), 32'h0);
    check_ifid("rst", 1'b0, NOP, 32'h0);
    check_val("rst.addr", 32'(imem_addr), 32'h0);

    // Run off the end of the 64-byte range.
    mem[3] = 32'hA000_0003;
    step();
    redirect_valid = 1'b1; redirect_target = 32'h30;
    step();
    redirect_valid = 1'b0;
    for (int i = 12; i < 16; i++) begin
      step();
      check_ifid("tail", 1'b1, 32'hA000_0000 + 32'(i), 32'(i * 4));
    end
    check_val("tail.fault", 32'(fault), 32'h0);
    check_val("wrap.addr", 32'(imem_addr), 32'h0);
    step();
    check_val("oor.fault", 32'(fault), 32'h1);
    check_ifid("oor", 1'b0, NOP, 32'h3C);
    step();
    check_val("oor.stay", 32'(if_id_valid), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the byte-addressable instruction memory; it consumes that memory's combinational 32-bit read data.
- Holds the program counter and drives the instruction-memory byte address.
- Registers the fetched word into the IF/ID pipeline register and handles stall, branch/jump redirect, halt-on-system-instruction and fault detection.
- Feeds the decode stage.

Parameters:
- ADDR_W, 6, instruction-memory byte-address width; the addressable range is 0 .. 2^ADDR_W-1.
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be 4-byte aligned.
- NOP_INST, 32'h0000_0013, bubble instruction (addi x0,x0,0) placed in IF/ID when it is not valid.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset; sampled on the rising clk edge.
- imem_addr  out  ADDR_W  byte address to instruction memory; equals pc[ADDR_W-1:0].
- imem_data  in  32  instruction word returned combinationally for imem_addr.
- stall  in  1  hazard stall from decode; holds PC and IF/ID.
- redirect_valid  in  1  taken branch/jump from a later stage.
- redirect_target  in  32  new PC when redirect_valid=1.
- if_id_valid  out  1  IF/ID holds a real instruction.
- if_id_inst  out  32  registered instruction.
- if_id_pc  out  32  PC of if_id_inst.
- halted  out  1  high in HALTED state.
- fault  out  1  high in FAULT state (sticky until reset).

Behaviour:
- Reset (rst=0 at an edge):
  - pc=RESET_PC, state=IDLE.
  - if_id_valid=0, if_id_inst=NOP_INST, if_id_pc=0, halted=0, fault=0.
- States and transitions:
  - IDLE: no fetch, IF/ID holds a bubble; moves to RUN next cycle unconditionally.
  - RUN: normal fetching.
  - HALTED: entered after a halt instruction is fetched.
  - FAULT: entered on an alignment or range error.
- Priority each edge in RUN: redirect > stall > advance.
- Advance (RUN, no stall, no redirect):
  - if_id_inst=imem_data, if_id_pc=pc, if_id_valid=1, pc=pc+4.
  - Fetch-to-IF/ID latency is 1 cycle.
- Stall (RUN, stall=1, redirect_valid=0): pc and all IF/ID outputs hold their values.
- Redirect (redirect_valid=1 in RUN or HALTED, regardless of stall):
  - pc=redirect_target.
  - IF/ID flushed: valid=0, inst=NOP_INST; if_id_pc holds.
  - State becomes RUN, and halted clears. A halt fetched on the wrong path is cancelled this way.
- Halt detection (RUN, advancing, imem_data equals 32'h0000_0073 ecall or 32'h0010_0073 ebreak):
  - The instruction is written into IF/ID as valid and pc is not incremented.
  - State becomes HALTED and halted=1 from the next cycle.
  - In HALTED: if_id_valid=0 and inst=NOP_INST after the first HALTED edge; pc holds; stall is ignored.
- Misaligned redirect (redirect_valid=1 and redirect_target[1:0]!=0):
  - State becomes FAULT and fault=1; IF/ID flushed; pc is loaded with the target for debug.
- Out-of-range fetch (RUN, about to advance, pc[31:ADDR_W]!=0):
  - No IF/ID write; IF/ID becomes a bubble.
  - State becomes FAULT and fault=1.
- FAULT: all inputs except rst are ignored; IF/ID stays a bubble; exit only via reset.
- PC arithmetic: 32-bit, with a plain increment by 4. PC values above the range never wrap silently; they raise the range fault.
- Reset mid-operation (stall, redirect or halt) fully overrides all other inputs on that edge.
- imem_addr is combinational from the pc register and is valid in every state.

Test Plan:
- Reset held 2 cycles, then release with memory words W0..W3 at 0,4,8,12 -> IDLE for 1 cycle with if_id_valid=0 and inst=0x00000013; then IF/ID shows (W0,pc 0), (W1,4), (W2,8) on consecutive cycles.
- Stall high for 3 cycles while IF/ID holds (W1,4) -> IF/ID and imem_addr=8 are unchanged for 3 cycles; after release, (W2,8) appears on the next edge.
- stall=1 and redirect_valid=1 with target 0x20 on the same edge -> IF/ID becomes a bubble, pc=0x20, and the next IF/ID is (mem[0x20],0x20).
- Word 0x00100073 at address 12 -> IF/ID shows (0x00100073,12) valid; halted=1 the following cycle; imem_addr stays 12 and later IF/ID entries are bubbles. Then redirect to 0x04 -> halted=0 and fetching resumes at 4.
- Redirect to 0x22 -> fault=1 and IF/ID is a bubble permanently; a later redirect to 0x00 is ignored; rst=0 for 1 cycle clears fault.
- Straight-line code to pc=60 with ADDR_W=6 -> (mem[60],60) is delivered; at pc=64 fault=1 and no valid IF/ID is produced.
